alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_pkg.sv | 15 +
 rtl/alu.sv | 39 +++
 rtl/alu_arbiter.sv | 111 +++++++++++
 tb/tb_alu_arbiter.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: ALUControl codes and arbiter state type shared by the ALU and its arbiter.
package alu_pkg;
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_ADDU = 4'b0001;
    localparam logic [3:0] ALU_SUB  = 4'b0010;
    localparam logic [3:0] ALU_SUBU = 4'b0011;
    localparam logic [3:0] ALU_AND  = 4'b0100;
    localparam logic [3:0] ALU_OR   = 4'b0101;
    localparam logic [3:0] ALU_XOR  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SLL  = 4'b1000;
    localparam logic [3:0] ALU_BEQ  = 4'b1001;
    localparam logic [3:0] ALU_BNE  = 4'b1010;
    typedef enum logic [1:0] {IDLE, EXEC, RESP} arb_state_t;
endpackage

// File: rtl/alu.sv
// alu: combinational 32-bit ALU; overflow is reported only for signed ADD/SUB.
module alu
    import alu_pkg::*;
(
    input  logic [3:0]  ctrl_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic [4:0]  sa_i,
    output logic [31:0] result_o,
    output logic        zero_o,
    output logic        ovf_o
);
    logic [31:0] sum, diff;
    assign sum  = a_i + b_i;
    assign diff = a_i - b_i;
    always_comb begin
        result_o = '0;
        ovf_o    = 1'b0;
        case (ctrl_i)
            ALU_ADD: begin
                result_o = sum;
                ovf_o    = (a_i[31] == b_i[31]) && (sum[31] != a_i[31]);
            end
            ALU_SUB: begin
                result_o = diff;
                ovf_o    = (a_i[31] != b_i[31]) && (diff[31] != a_i[31]);
            end
            ALU_ADDU:                   result_o = sum;
            ALU_SUBU, ALU_BEQ, ALU_BNE: result_o = diff;
            ALU_AND:                    result_o = a_i & b_i;
            ALU_OR:                     result_o = a_i | b_i;
            ALU_XOR:                    result_o = a_i ^ b_i;
            ALU_SLT:                    result_o = {31'b0, $signed(a_i) < $signed(b_i)};
            ALU_SLL:                    result_o = b_i << sa_i;
            default:                    result_o = '0;
        endcase
    end
    assign zero_o = result_o == '0;
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter sharing one ALU between two requesters,
// one operation in flight, results held until the owning requester consumes them.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [3:0]       req0_ctrl,
    input  logic             req0_src,
    input  logic [31:0]      req0_a,
    input  logic [31:0]      req0_b,
    input  logic [31:0]      req0_imm,
    input  logic [4:0]       req0_sa,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [3:0]       req1_ctrl,
    input  logic             req1_src,
    input  logic [31:0]      req1_a,
    input  logic [31:0]      req1_b,
    input  logic [31:0]      req1_imm,
    input  logic [4:0]       req1_sa,
    output logic             resp0_valid,
    input  logic             resp0_ready,
    output logic             resp1_valid,
    input  logic             resp1_ready,
    output logic [31:0]      resp_result,
    output logic             resp_zero,
    output logic             resp_ovf,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);
    arb_state_t       state_q;
    logic             owner_q, last_q, zero_q, ovf_q;
    logic [3:0]       ctrl_q;
    logic [31:0]      a_q, b_q, result_q;
    logic [4:0]       sa_q;
    logic [CNT_W-1:0] cnt_q;
    logic             idle, gnt1, accept, take;
    logic [31:0]      alu_result, b0_d, b1_d;
    logic             alu_zero, alu_ovf;

    assign idle = state_q == IDLE;
    // last_q=1 means requester 1 was served last, so requester 0 wins a tie
    assign gnt1        = req1_valid && (!req0_valid || !last_q);
    assign req0_ready  = idle && req0_valid && !gnt1;
    assign req1_ready  = idle && gnt1;
    assign accept      = req0_ready || req1_ready;
    assign resp0_valid = state_q == RESP && !owner_q;
    assign resp1_valid = state_q == RESP && owner_q;
    assign take        = (resp0_valid && resp0_ready) || (resp1_valid && resp1_ready);
    assign b0_d        = req0_src ? req0_imm : req0_b;
    assign b1_d        = req1_src ? req1_imm : req1_b;
    assign busy        = !idle;
    assign resp_result = result_q;
    assign resp_zero   = zero_q;
    assign resp_ovf    = ovf_q;
    assign op_count    = cnt_q;

    alu u_alu (
        .ctrl_i  (ctrl_q),
        .a_i     (a_q),
        .b_i     (b_q),
        .sa_i    (sa_q),
        .result_o(alu_result),
        .zero_o  (alu_zero),
        .ovf_o   (alu_ovf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            owner_q  <= 1'b0;
            last_q   <= 1'b1;
            ctrl_q   <= '0;
            a_q      <= '0;
            b_q      <= '0;
            sa_q     <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            case (state_q)
                IDLE: if (accept) begin
                    owner_q <= gnt1;
                    last_q  <= gnt1;
                    ctrl_q  <= gnt1 ? req1_ctrl : req0_ctrl;
                    a_q     <= gnt1 ? req1_a : req0_a;
                    b_q     <= gnt1 ? b1_d : b0_d;
                    sa_q    <= gnt1 ? req1_sa : req0_sa;
                    state_q <= EXEC;
                end
                EXEC: begin
                    result_q <= alu_result;
                    zero_q   <= alu_zero;
                    ovf_q    <= alu_ovf;
                    state_q  <= RESP;
                end
                RESP: if (take) begin
                    state_q <= IDLE;
                    cnt_q   <= &cnt_q ? cnt_q : cnt_q + CNT_W'(1);
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed tests of arbitration, ALU results, stalls, reset and counter saturation.
module tb_alu_arbiter;
    import alu_pkg::*;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        req0_valid = 0, req0_ready, req0_src = 0, req1_valid = 0, req1_ready, req1_src = 0;
    logic [3:0]  req0_ctrl = 0, req1_ctrl = 0;
    logic [31:0] req0_a = 0, req0_b = 0, req0_imm = 0, req1_a = 0, req1_b = 0, req1_imm = 0;
    logic [4:0]  req0_sa = 0, req1_sa = 0;
    logic        resp0_valid, resp0_ready = 0, resp1_valid, resp1_ready = 0;
    logic [31:0] resp_result;
    logic        resp_zero, resp_ovf, busy;
    logic [3:0]  op_count;
    int checks = 0, errors = 0, exp_cnt = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_ctrl(req0_ctrl), .req0_src(req0_src),
        .req0_a(req0_a), .req0_b(req0_b), .req0_imm(req0_imm), .req0_sa(req0_sa),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_ctrl(req1_ctrl), .req1_src(req1_src),
        .req1_a(req1_a), .req1_b(req1_b), .req1_imm(req1_imm), .req1_sa(req1_sa),
        .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
        .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
        .resp_result(resp_result), .resp_zero(resp_zero), .resp_ovf(resp_ovf),
        .busy(busy), .op_count(op_count)
    );

    task automatic set_req(input bit n, input logic v, input logic [3:0] c, input logic s,
                           input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                           input logic [4:0] sa);
        if (n) begin
            req1_valid = v; req1_ctrl = c; req1_src = s; req1_a = a; req1_b = b; req1_imm = imm; req1_sa = sa;
        end else begin
            req0_valid = v; req0_ctrl = c; req0_src = s; req0_a = a; req0_b = b; req0_imm = imm; req0_sa = sa;
        end
    endtask

    // One complete solo transaction from requester n, checked in every phase.
    task automatic run_op(input string nm, input bit n, input logic [3:0] c, input logic s,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                          input logic [4:0] sa, input logic [31:0] er, input logic ez, input logic eo);
        @(negedge clk);
        set_req(n, 1'b1, c, s, a, b, imm, sa);
        #1;
        checks++;
        if ({req1_ready, req0_ready} !== (n ? 2'b10 : 2'b01)) begin
            errors++;
            $display("FAIL %s grant: ready1/0=%b expected %b", nm, {req1_ready, req0_ready}, n ? 2'b10 : 2'b01);
        end
        @(negedge clk);
        if (n) req1_valid = 1'b0; else req0_valid = 1'b0;
        checks++;
        if ({busy, req1_ready, req0_ready, resp1_valid, resp0_valid} !== 5'b10000) begin
            errors++;
            $display("FAIL %s exec: busy/rdy1/rdy0/rv1/rv0=%b expected 10000", nm,
                     {busy, req1_ready, req0_ready, resp1_valid, resp0_valid});
        end
        @(negedge clk);
        checks++;
        if ({resp1_valid, resp0_valid} !== (n ? 2'b10 : 2'b01)) begin
            errors++;
            $display("FAIL %s resp_valid: got %b expected %b", nm, {resp1_valid, resp0_valid}, n ? 2'b10 : 2'b01);
        end
        checks++;
        if (resp_result !== er || resp_zero !== ez || resp_ovf !== eo) begin
            errors++;
            $display("FAIL %s result: got %h z=%b o=%b expected %h z=%b o=%b", nm,
                     resp_result, resp_zero, resp_ovf, er, ez, eo);
        end
        if (n) resp1_ready = 1'b1; else resp0_ready = 1'b1;
        @(negedge clk);
        resp0_ready = 1'b0;
        resp1_ready = 1'b0;
        exp_cnt = exp_cnt == 15 ? 15 : exp_cnt + 1;
        checks++;
        if (op_count !== 4'(exp_cnt) || busy !== 1'b0 || {resp1_valid, resp0_valid} !== 2'b00) begin
            errors++;
            $display("FAIL %s done: op_count=%0d busy=%b rv=%b expected %0d 0 00", nm,
                     op_count, busy, {resp1_valid, resp0_valid}, exp_cnt);
        end
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, resp0_valid, resp1_valid, resp_zero, resp_ovf} !== 5'b0 || resp_result !== 32'h0 || op_count !== 4'h0) begin
            errors++;
            $display("FAIL reset_hold: busy=%b rv0=%b rv1=%b z=%b o=%b res=%h cnt=%0d expected all 0",
                     busy, resp0_valid, resp1_valid, resp_zero, resp_ovf, resp_result, op_count);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, req0_ready, req1_ready} !== 3'b000) begin
            errors++;
            $display("FAIL reset_release: busy/rdy0/rdy1=%b expected 000", {busy, req0_ready, req1_ready});
        end
    endtask

    task automatic test_arbitration;
        @(negedge clk);
        set_req(0, 1'b1, ALU_SUB, 1'b0, 32'd20, 32'd5, 32'd0, 5'd0);
        set_req(1, 1'b1, ALU_SLL, 1'b0, 32'd0, 32'd1, 32'd0, 5'd4);
        #1;
        checks++;
        if ({req1_ready, req0_ready} !== 2'b01) begin
            errors++;
            $display("FAIL arb_first: ready1/0=%b expected 01", {req1_ready, req0_ready});
        end
        @(negedge clk);
        checks++;
        if ({req1_ready, req0_ready} !== 2'b00 || busy !== 1'b1) begin
            errors++;
            $display("FAIL arb_exec: ready1/0=%b busy=%b expected 00 1", {req1_ready, req0_ready}, busy);
        end
        @(negedge clk);
        checks++;
        if (resp0_valid !== 1'b1 || resp1_valid !== 1'b0 || resp_result !== 32'd15) begin
            errors++;
            $display("FAIL arb_resp0: rv0=%b rv1=%b res=%0d expected 1 0 15", resp0_valid, resp1_valid, resp_result);
        end
        resp0_ready = 1'b1;
        @(negedge clk);
        resp0_ready = 1'b0;
        exp_cnt++;
        #1;
        checks++;
        if ({req1_ready, req0_ready} !== 2'b10 || op_count !== 4'(exp_cnt)) begin
            errors++;
            $display("FAIL arb_second: ready1/0=%b cnt=%0d expected 10 %0d", {req1_ready, req0_ready}, op_count, exp_cnt);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (resp1_valid !== 1'b1 || resp0_valid !== 1'b0 || resp_result !== 32'd16 || resp_ovf !== 1'b0) begin
            errors++;
            $display("FAIL arb_resp1: rv1=%b rv0=%b res=%0d o=%b expected 1 0 16 0",
                     resp1_valid, resp0_valid, resp_result, resp_ovf);
        end
        resp1_ready = 1'b1;
        @(negedge clk);
        resp1_ready = 1'b0;
        exp_cnt++;
        #1;
        checks++;
        if ({req1_ready, req0_ready} !== 2'b01) begin
            errors++;
            $display("FAIL arb_third: ready1/0=%b expected 01", {req1_ready, req0_ready});
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic test_add;
        run_op("add", 0, ALU_ADD, 1'b0, 32'd10, 32'd20, 32'd0, 5'd0, 32'd30, 1'b0, 1'b0);
    endtask

    task automatic test_flags;
        run_op("add_ovf", 1, ALU_ADD, 1'b0, 32'h7FFF_FFFF, 32'd1, 32'd0, 5'd0, 32'h8000_0000, 1'b0, 1'b1);
        run_op("beq_eq", 1, ALU_BEQ, 1'b0, 32'd7, 32'd7, 32'd0, 5'd0, 32'd0, 1'b1, 1'b0);
        run_op("bne_ne", 0, ALU_BNE, 1'b0, 32'd7, 32'd8, 32'd0, 5'd0, 32'hFFFF_FFFF, 1'b0, 1'b0);
        run_op("sub_ovf", 0, ALU_SUB, 1'b0, 32'h8000_0000, 32'd1, 32'd0, 5'd0, 32'h7FFF_FFFF, 1'b0, 1'b1);
        run_op("addu_wrap", 1, ALU_ADDU, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 5'd0, 32'd0, 1'b1, 1'b0);
        run_op("and", 0, ALU_AND, 1'b0, 32'h0000_F0F0, 32'h0000_FF00, 32'd0, 5'd0, 32'h0000_F000, 1'b0, 1'b0);
        run_op("slt", 1, ALU_SLT, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 5'd0, 32'd1, 1'b0, 1'b0);
    endtask

    task automatic test_src;
        run_op("src_imm", 0, ALU_ADD, 1'b1, 32'd3, 32'hxxxx_xxxx, 32'd5, 5'd0, 32'd8, 1'b0, 1'b0);
        run_op("src_reg", 1, ALU_OR, 1'b0, 32'h0000_0030, 32'h0000_0009, 32'hxxxx_xxxx, 5'd0, 32'h0000_0039, 1'b0, 1'b0);
    endtask

    task automatic test_stall;
        @(negedge clk);
        set_req(0, 1'b1, ALU_ADD, 1'b0, 32'd1, 32'd2, 32'd0, 5'd0);
        @(negedge clk);
        req0_valid = 1'b0;
        set_req(1, 1'b1, ALU_XOR, 1'b0, 32'hFF, 32'h0F, 32'd0, 5'd0);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (resp0_valid !== 1'b1 || resp1_valid !== 1'b0 || resp_result !== 32'd3 ||
                {req1_ready, req0_ready} !== 2'b00 || busy !== 1'b1) begin
                errors++;
                $display("FAIL stall_%0d: rv0=%b rv1=%b res=%0d rdy=%b busy=%b expected 1 0 3 00 1",
                         i, resp0_valid, resp1_valid, resp_result, {req1_ready, req0_ready}, busy);
            end
            @(negedge clk);
        end
        resp0_ready = 1'b1;
        @(negedge clk);
        resp0_ready = 1'b0;
        exp_cnt = exp_cnt == 15 ? 15 : exp_cnt + 1;
        #1;
        checks++;
        if ({req1_ready, req0_ready} !== 2'b10 || op_count !== 4'(exp_cnt)) begin
            errors++;
            $display("FAIL stall_release: ready1/0=%b cnt=%0d expected 10 %0d", {req1_ready, req0_ready}, op_count, exp_cnt);
        end
        req1_valid = 1'b0;
    endtask

    task automatic test_reset_exec;
        @(negedge clk);
        set_req(0, 1'b1, ALU_ADD, 1'b0, 32'd100, 32'd200, 32'd0, 5'd0);
        @(negedge clk);
        req0_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        exp_cnt = 0;
        #1;
        checks++;
        if ({busy, resp0_valid, resp1_valid, resp_zero, resp_ovf} !== 5'b0 || resp_result !== 32'h0 || op_count !== 4'h0) begin
            errors++;
            $display("FAIL reset_exec: busy=%b rv0=%b rv1=%b z=%b o=%b res=%h cnt=%0d expected all 0",
                     busy, resp0_valid, resp1_valid, resp_zero, resp_ovf, resp_result, op_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if ({busy, resp0_valid, resp1_valid} !== 3'b000) begin
                errors++;
                $display("FAIL reset_after_%0d: busy/rv0/rv1=%b expected 000", i, {busy, resp0_valid, resp1_valid});
            end
        end
    endtask

    task automatic test_saturation;
        for (int k = 0; k < 16; k++)
            run_op("sat", k[0], ALU_ADD, 1'b1, 32'(k), 32'd0, 32'd1, 5'd0, 32'(k + 1), 1'b0, 1'b0);
        checks++;
        if (op_count !== 4'd15) begin
            errors++;
            $display("FAIL sat_final: op_count=%0d expected 15", op_count);
        end
    endtask

    initial begin
        test_reset();
        test_arbitration();
        test_add();
        test_flags();
        test_src();
        test_stall();
        test_reset_exec();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
